binary_mul_pipe_param: RTL

Parametrised, fully pipelined array multiplier. It succeeds the fixed 4x4 row-pipelined signed multiplier.
- Generalises operand width.
- Supports per-transaction signed/unsigned mode.
- Produces the full 2*WIDTH-bit product.
- Carries a valid bit through every stage, with global stall via en.
- Sits in the arithmetic datapath of the Binary_mul family, feeding MAC/accumulator blocks.

---
 rtl/binary_mul_pkg.sv | 27 ++
 rtl/binary_mul_row_stage.sv | 64 ++++++
 rtl/binary_mul_pipe_param.sv | 86 ++++++++
 3 files changed

// File: rtl/binary_mul_pkg.sv
// Shared types and helpers for the pipelined binary multiplier family.
package binary_mul_pkg;

  localparam int unsigned WIDTH_MAX = 16;
  localparam int unsigned PROD_MAX  = 2 * WIDTH_MAX;

  typedef enum logic {
    MUL_UNSIGNED = 1'b0,
    MUL_SIGNED   = 1'b1
  } mul_mode_e;

  // One pipeline slot; sized for the widest legal operand, narrower builds use the low bits.
  typedef struct packed {
    logic [PROD_MAX-1:0]  sum;
    logic [PROD_MAX-1:0]  carry;
    logic [WIDTH_MAX-1:0] a;
    logic [WIDTH_MAX-1:0] b;
    mul_mode_e            mode;
    logic                 valid;
  } mul_stage_t;

  // Latency in enabled cycles: one register per partial-product row plus the final adder.
  function automatic int unsigned calc_lat(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/binary_mul_row_stage.sv
// One partial-product row: carry-save adds row ROW into the running sum/carry and registers it.
module binary_mul_row_stage
  import binary_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ROW   = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en_i,
  input  logic       clr_valid_i,
  input  mul_stage_t stage_i,
  output mul_stage_t stage_o
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] a_w;
  logic             b_bit;
  logic             neg;
  logic [PW-1:0]    ext_a;
  logic [PW-1:0]    pp;
  logic [PW-1:0]    s_in;
  logic [PW-1:0]    c_in;
  logic [PW-1:0]    sum_d;
  logic [PW-1:0]    maj;
  logic [PW-1:0]    carry_d;
  mul_stage_t       stage_d;
  mul_stage_t       stage_q;

  // Row k partial product; the top row of a signed multiply subtracts, using ~x plus a carry-in.
  always_comb begin
    a_w     = stage_i.a[WIDTH-1:0];
    b_bit   = stage_i.b[0];
    s_in    = stage_i.sum[PW-1:0];
    c_in    = stage_i.carry[PW-1:0];
    ext_a   = {{WIDTH{(stage_i.mode == MUL_SIGNED) & a_w[WIDTH-1]}}, a_w};
    neg     = (ROW == WIDTH - 1) && (stage_i.mode == MUL_SIGNED) && b_bit;
    pp      = '0;
    if (b_bit) pp = ext_a << ROW;
    if (neg)   pp = ~(ext_a << ROW);
    sum_d   = s_in ^ c_in ^ pp;
    maj     = (s_in & c_in) | (s_in & pp) | (c_in & pp);
    carry_d = (maj << 1) | PW'(neg);
    stage_d       = stage_i;
    stage_d.sum   = PROD_MAX'(sum_d);
    stage_d.carry = PROD_MAX'(carry_d);
    stage_d.b     = stage_i.b >> 1;
  end

  // Stage register; a flush clears only the valid bit and leaves data in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else if (clr_valid_i) begin
      stage_q.valid <= 1'b0;
    end else if (en_i) begin
      stage_q <= stage_d;
    end
  end

  assign stage_o = stage_q;

endmodule

// File: rtl/binary_mul_pipe_param.sv
// Fully pipelined WIDTH x WIDTH array multiplier, signed/unsigned per transaction.
// Optional flush port enabled by defining BINARY_MUL_FLUSH_EN.
module binary_mul_pipe_param
  import binary_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
`ifdef BINARY_MUL_FLUSH_EN
  input  logic               flush,
`endif
  input  logic               en,
  input  logic               in_valid,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               out_valid
);

  localparam int unsigned LAT  = calc_lat(WIDTH);
  localparam int unsigned ROWS = LAT - 1;
  localparam int unsigned PW   = 2 * WIDTH;

  mul_stage_t        chain [0:ROWS];
  mul_stage_t        stage_in;
  mul_stage_t        last;
  logic              clr_valid;
  logic [PW-1:0]     p_d;
  logic [PW-1:0]     p_q;
  logic              out_valid_q;
  logic              unused_last;

`ifdef BINARY_MUL_FLUSH_EN
  assign clr_valid = flush;
`else
  assign clr_valid = 1'b0;
`endif

  // Pack the incoming transaction into an empty slot.
  always_comb begin
    stage_in       = '0;
    stage_in.a     = WIDTH_MAX'(a);
    stage_in.b     = WIDTH_MAX'(b);
    stage_in.mode  = mul_mode_e'(signed_mode);
    stage_in.valid = in_valid;
  end

  assign chain[0] = stage_in;

  for (genvar k = 0; k < ROWS; k++) begin : g_row
    binary_mul_row_stage #(
      .WIDTH (WIDTH),
      .ROW   (k)
    ) u_row (
      .clk         (clk),
      .rst_n       (rst_n),
      .en_i        (en),
      .clr_valid_i (clr_valid),
      .stage_i     (chain[k]),
      .stage_o     (chain[k+1])
    );
  end

  assign last        = chain[ROWS];
  assign p_d         = last.sum[PW-1:0] + last.carry[PW-1:0];
  assign unused_last = ^last;

  // Final carry-propagate stage and output valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else if (clr_valid) begin
      out_valid_q <= 1'b0;
    end else if (en) begin
      p_q         <= p_d;
      out_valid_q <= last.valid;
    end
  end

  assign p         = p_q;
  assign out_valid = out_valid_q;

endmodule
